tetris_step_scheduler: RTL and testbench

Sequencer for the falling tetromino. It arbitrates between player move requests and the gravity tick, and issues one move at a time to the collision checker through a request/acknowledge handshake. It commits or discards the move, locks the piece when it can no longer fall, and checks the lock against the top-of-well limit. It runs the line-clear and spawn steps in order. It sits between the key/timer front end and the board datapath.

---
 rtl/tetris_step_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tetris_step_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_step_scheduler.sv
// tetris_step_scheduler
// Move sequencer for the falling tetromino. It queues player keys and gravity
// ticks as pending flags and serves them one at a time through the collision
// checker handshake. It then commits or discards each move. When a piece can no
// longer fall it is locked and tested against the top of the well. After that
// the line clear and the next spawn run.
//
// Optional feature: define LOCK_DELAY_EN to give the player one grace window
// after the first failed fall. A committed left/right/rotate re-opens it.
//
// Piece occupancy: `float` row 0 is the top nibble float[15:12], which is bits
// 0..3 when the word is numbered from its MSB. Row r is float[15-4r -: 4].
module tetris_step_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_rotate,
    input  logic        key_down,
    input  logic        tick,
    input  logic [4:0]  pos_y,
    input  logic [15:0] float,
    output logic        chk_req,
    output logic [2:0]  chk_op,
    input  logic        chk_ack,
    input  logic        chk_ok,
    output logic        commit,
    output logic        lock,
    output logic        clear_req,
    input  logic        clear_done,
    output logic        spawn,
    output logic        game_over,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_LOCK  = 3'd4,
        S_CLEAR = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    localparam logic [2:0] OP_DOWN  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_SPAWN = 3'd4;

    // Pending-flag slots: tick and down share op 0 but keep separate flags.
    localparam int NF     = 5;
    localparam int F_TICK = 0;
    localparam int F_DOWN = 1;
    localparam int F_ROT  = 2;
    localparam int F_LEFT = 3;
    localparam int F_RGHT = 4;

    state_t          state_reg;
    logic            chk_req_reg;
    logic [2:0]      chk_op_reg;
    logic            commit_reg;
    logic            lock_reg;
    logic            clear_req_reg;
    logic            spawn_reg;
    logic            game_over_reg;
`ifdef LOCK_DELAY_EN
    logic            grace_reg;
`endif

    logic [NF-1:0]   req_pulse;
    logic [NF-1:0]   pend;
    logic [NF-1:0]   pick_mask;
    logic [NF-1:0]   issue_clr;
    logic [2:0]      pick_op;
    logic            pick_valid;
    logic            ack_seen;
    logic            flush;
    logic [3:0]      row_hit;
    logic            overflow;

    assign req_pulse = {key_right, key_left, key_rotate, key_down, tick};

    // An ack only counts while the request is actually being presented.
    assign ack_seen = chk_req_reg && chk_ack;

    // Flags are emptied while idle/over and on every path that ends the game.
    assign flush = (state_reg == S_IDLE) || (state_reg == S_OVER)
                || ((state_reg == S_LOCK) && overflow)
                || ((state_reg == S_CHECK) && ack_seen && !chk_ok && (chk_op_reg == OP_SPAWN));

    assign issue_clr = (state_reg == S_WAIT) ? pick_mask : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NF; gi++) begin : g_pend
            logic flag_reg;
            // One sticky request flag per source; a new pulse beats an issue clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flag_reg <= 1'b0;
                end else if (flush) begin
                    flag_reg <= 1'b0;
                end else if (req_pulse[gi]) begin
                    flag_reg <= 1'b1;
                end else if (issue_clr[gi]) begin
                    flag_reg <= 1'b0;
                end
            end
            assign pend[gi] = flag_reg;
        end

        for (gi = 0; gi < 4; gi++) begin : g_row
            // Row gi overflows when occupied and the anchor is at or below row 23-gi.
            assign row_hit[gi] = (|float[15-4*gi -: 4]) && (pos_y >= 5'(23 - gi));
        end
    endgenerate

    assign overflow = |row_hit;

    // Priority pick: tick/down, then rotate, left, right.
    always_comb begin
        pick_valid = |pend;
        pick_op    = OP_DOWN;
        pick_mask  = '0;
        if (pend[F_TICK] || pend[F_DOWN]) begin
            pick_op   = OP_DOWN;
            pick_mask[F_TICK] = 1'b1;
            pick_mask[F_DOWN] = 1'b1;
        end else if (pend[F_ROT]) begin
            pick_op   = OP_ROT;
            pick_mask[F_ROT] = 1'b1;
        end else if (pend[F_LEFT]) begin
            pick_op   = OP_LEFT;
            pick_mask[F_LEFT] = 1'b1;
        end else if (pend[F_RGHT]) begin
            pick_op   = OP_RIGHT;
            pick_mask[F_RGHT] = 1'b1;
        end
    end

    // Main sequencer with registered handshake and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            chk_req_reg   <= 1'b0;
            chk_op_reg    <= OP_DOWN;
            commit_reg    <= 1'b0;
            lock_reg      <= 1'b0;
            clear_req_reg <= 1'b0;
            spawn_reg     <= 1'b0;
            game_over_reg <= 1'b0;
`ifdef LOCK_DELAY_EN
            grace_reg     <= 1'b0;
`endif
        end else begin
            commit_reg <= 1'b0;
            lock_reg   <= 1'b0;
            spawn_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_SPAWN;
                        spawn_reg <= 1'b1;
`ifdef LOCK_DELAY_EN
                        grace_reg <= 1'b0;
`endif
                    end
                end
                S_SPAWN: begin
                    state_reg  <= S_CHECK;
                    chk_op_reg <= OP_SPAWN;
                end
                S_WAIT: begin
                    if (pick_valid) begin
                        state_reg  <= S_CHECK;
                        chk_op_reg <= pick_op;
                    end
                end
                S_CHECK: begin
                    if (ack_seen) begin
                        chk_req_reg <= 1'b0;
                        if (chk_ok) begin
                            state_reg <= S_WAIT;
                            if (chk_op_reg != OP_SPAWN) begin
                                commit_reg <= 1'b1;
                            end
`ifdef LOCK_DELAY_EN
                            if (chk_op_reg == OP_LEFT || chk_op_reg == OP_RIGHT || chk_op_reg == OP_ROT) begin
                                grace_reg <= 1'b0;
                            end
`endif
                        end else if (chk_op_reg == OP_DOWN) begin
`ifdef LOCK_DELAY_EN
                            if (!grace_reg) begin
                                grace_reg <= 1'b1;
                                state_reg <= S_WAIT;
                            end else begin
                                grace_reg <= 1'b0;
                                state_reg <= S_LOCK;
                                lock_reg  <= 1'b1;
                            end
`else
                            state_reg <= S_LOCK;
                            lock_reg  <= 1'b1;
`endif
                        end else if (chk_op_reg == OP_SPAWN) begin
                            state_reg     <= S_OVER;
                            game_over_reg <= 1'b1;
                        end else begin
                            state_reg <= S_WAIT;
                        end
                    end else begin
                        chk_req_reg <= 1'b1;
                    end
                end
                S_LOCK: begin
                    if (overflow) begin
                        state_reg     <= S_OVER;
                        game_over_reg <= 1'b1;
                    end else begin
                        state_reg     <= S_CLEAR;
                        clear_req_reg <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clear_done) begin
                        clear_req_reg <= 1'b0;
                        state_reg     <= S_SPAWN;
                        spawn_reg     <= 1'b1;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        game_over_reg <= 1'b0;
                        state_reg     <= S_SPAWN;
                        spawn_reg     <= 1'b1;
`ifdef LOCK_DELAY_EN
                        grace_reg     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign chk_req   = chk_req_reg;
    assign chk_op    = chk_op_reg;
    assign commit    = commit_reg;
    assign lock      = lock_reg;
    assign clear_req = clear_req_reg;
    assign spawn     = spawn_reg;
    assign game_over = game_over_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_tetris_step_scheduler.sv
// Scoreboard bench for tetris_step_scheduler: a transaction-level model plans
// the expected event stream (check requests, commits, locks, clears, spawns,
// game over) and the checker responses; a monitor compares DUT events in order.
`timescale 1ns/1ps
module tb_tetris_step_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        key_left = 1'b0, key_right = 1'b0, key_rotate = 1'b0, key_down = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  pos_y = 5'd0;
    logic [15:0] float_w = 16'h0;
    logic        chk_req;
    logic [2:0]  chk_op;
    logic        chk_ack = 1'b0, chk_ok = 1'b0;
    logic        commit, lock, clear_req, spawn, game_over;
    logic        clear_done = 1'b0;
    logic [2:0]  state;

    tetris_step_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .key_left(key_left), .key_right(key_right), .key_rotate(key_rotate), .key_down(key_down),
        .tick(tick), .pos_y(pos_y), .float(float_w),
        .chk_req(chk_req), .chk_op(chk_op), .chk_ack(chk_ack), .chk_ok(chk_ok),
        .commit(commit), .lock(lock), .clear_req(clear_req), .clear_done(clear_done),
        .spawn(spawn), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

`ifdef LOCK_DELAY_EN
    localparam bit LOCK_DELAY = 1'b1;
`else
    localparam bit LOCK_DELAY = 1'b0;
`endif

    localparam int EV_CHK = 0, EV_COMMIT = 1, EV_LOCK = 2, EV_SPAWN = 3, EV_CLEAR = 4, EV_OVER = 5;

    typedef struct { int kind; int op; int st; } ev_t;

    ev_t exp_q[$];
    bit  resp_q[$];
    bit  force_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_ack_cyc = -100;
    bit  hold_ack = 1'b0;
    bit  m_over = 1'b1;   // model: not in a running game (IDLE or OVER)
    bit  m_grace = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            EV_CHK:    return "check";
            EV_COMMIT: return "commit";
            EV_LOCK:   return "lock";
            EV_SPAWN:  return "spawn";
            EV_CLEAR:  return "clear";
            default:   return "over";
        endcase
    endfunction

    function automatic bit next_ok(int pct);
        if (force_q.size() > 0) return force_q.pop_front();
        return ($urandom_range(99) < pct);
    endfunction

    function automatic void push_ev(int kind, int op, int st);
        ev_t e;
        e.kind = kind; e.op = op; e.st = st;
        exp_q.push_back(e);
    endfunction

    // Top-of-well rule: row r (top nibble = row 0) occupied and pos_y >= 23-r.
    function automatic bit overflow_of(logic [15:0] f, int y);
        for (int r = 0; r < 4; r++) begin
            if ((((f >> (12 - 4 * r)) & 16'hF) != 16'h0) && (y >= 23 - r)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void plan_spawn();
        bit ok;
        push_ev(EV_SPAWN, 0, 1);
        ok = next_ok(85);
        resp_q.push_back(ok);
        push_ev(EV_CHK, 4, 3);
        if (!ok) begin
            push_ev(EV_OVER, 0, 6);
            m_over = 1'b1;
        end
    endfunction

    function automatic void plan_keys(bit t, bit d, bit r, bit l, bit rt, logic [15:0] f, int y);
        bit pd, pr, pl, prt, ok;
        int op;
        pd = t | d; pr = r; pl = l; prt = rt;
        while (!m_over && (pd || pr || pl || prt)) begin
            if (pd)      begin op = 0; pd = 1'b0; end
            else if (pr) begin op = 3; pr = 1'b0; end
            else if (pl) begin op = 1; pl = 1'b0; end
            else         begin op = 2; prt = 1'b0; end
            ok = next_ok(op == 0 ? 50 : 70);
            resp_q.push_back(ok);
            push_ev(EV_CHK, op, 3);
            if (ok) begin
                push_ev(EV_COMMIT, op, 2);
                if (op != 0) m_grace = 1'b0;
            end else if (op == 0) begin
                if (LOCK_DELAY && !m_grace) begin
                    m_grace = 1'b1;
                end else begin
                    m_grace = 1'b0;
                    push_ev(EV_LOCK, 0, 4);
                    if (overflow_of(f, y)) begin
                        push_ev(EV_OVER, 0, 6);
                        m_over = 1'b1;
                    end else begin
                        push_ev(EV_CLEAR, 0, 5);
                        plan_spawn();
                    end
                end
            end
        end
    endfunction

    task automatic check_eq(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic see(int kind, int op, int st);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %s op=%0d state=%0d, required none (cycle %0d)",
                     kname(kind), op, st, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.op != op || e.st != st) begin
                n_err++;
                $display("FAIL event: got %s op=%0d state=%0d, required %s op=%0d state=%0d (cycle %0d)",
                         kname(kind), op, st, kname(e.kind), e.op, e.st, cyc);
            end else begin
                $display("ok  %s op=%0d state=%0d cycle=%0d", kname(kind), op, st, cyc);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and checks handshake timing.
    initial begin
        bit prev_req = 1'b0, prev_clr = 1'b0, prev_go = 1'b0;
        int held_op = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0; prev_clr = 1'b0; prev_go = 1'b0;
                continue;
            end
            if (chk_req && prev_req) check_eq("chk_op_stable", int'(chk_op), held_op);
            if (chk_req && !prev_req) begin
                held_op = int'(chk_op);
                see(EV_CHK, int'(chk_op), int'(state));
            end
            if (commit) begin
                see(EV_COMMIT, int'(chk_op), int'(state));
                check_eq("commit_latency", cyc, last_ack_cyc + 1);
            end
            if (lock) begin
                see(EV_LOCK, 0, int'(state));
                check_eq("lock_latency", cyc, last_ack_cyc + 1);
            end
            if (spawn) see(EV_SPAWN, 0, int'(state));
            if (clear_req && !prev_clr) see(EV_CLEAR, 0, int'(state));
            if (game_over && !prev_go) see(EV_OVER, 0, int'(state));
            prev_req = chk_req; prev_clr = clear_req; prev_go = game_over;
        end
    end

    // Collision-checker responder: random ack delay, plus stray acks while idle.
    initial begin
        bit in_req = 1'b0;
        int wcnt = 0;
        bit ok;
        forever begin
            @(negedge clk);
            chk_ack = 1'b0; chk_ok = 1'b0;
            if (!rst_n) begin
                in_req = 1'b0;
                continue;
            end
            if (chk_req && !hold_ack) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt = $urandom_range(2);
                end
                if (wcnt == 0) begin
                    if (resp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL resp_underflow: got a check request op=%0d, required none (cycle %0d)", chk_op, cyc);
                        ok = 1'b1;
                    end else begin
                        ok = resp_q.pop_front();
                    end
                    chk_ack = 1'b1; chk_ok = ok;
                    last_ack_cyc = cyc;
                    in_req = 1'b0;
                end else begin
                    wcnt--;
                end
            end else if (!chk_req) begin
                in_req = 1'b0;
                if ($urandom_range(7) == 0) begin
                    chk_ack = 1'b1;
                    chk_ok = 1'($urandom_range(1));
                end
            end
        end
    end

    // Line-clear responder.
    initial begin
        forever begin
            @(negedge clk);
            clear_done = 1'b0;
            if (rst_n && clear_req && ($urandom_range(2) == 0)) clear_done = 1'b1;
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() > 0 || resp_q.size() > 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() > 0 || resp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d events and %0d acks outstanding, required 0", exp_q.size(), resp_q.size());
            exp_q.delete();
            resp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse(bit st, bit t, bit d, bit r, bit l, bit rt);
        @(negedge clk);
        start = st; tick = t; key_down = d; key_rotate = r; key_left = l; key_right = rt;
        @(negedge clk);
        start = 1'b0; tick = 1'b0; key_down = 1'b0; key_rotate = 1'b0; key_left = 1'b0; key_right = 1'b0;
    endtask

    task automatic do_start();
        if (m_over) begin
            m_over = 1'b0;
            m_grace = 1'b0;
            plan_spawn();
        end
        force_q.delete();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain();
    endtask

    task automatic do_keys(bit t, bit d, bit r, bit l, bit rt, logic [15:0] f, int y);
        @(negedge clk);
        float_w = f;
        pos_y = 5'(y);
        plan_keys(t, d, r, l, rt, f, y);
        force_q.delete();
        pulse(1'b0, t, d, r, l, rt);
        wait_drain();
    endtask

    logic [15:0] shapes [8] = '{16'h0F00, 16'hF000, 16'h000F, 16'h00F0, 16'h0660, 16'h4E00, 16'h0072, 16'h8000};

    initial begin
        int n;
        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", int'(state), 0);
        check_eq("reset_chk_req", int'(chk_req), 0);
        check_eq("reset_chk_op", int'(chk_op), 0);
        check_eq("reset_commit", int'(commit), 0);
        check_eq("reset_lock", int'(lock), 0);
        check_eq("reset_clear_req", int'(clear_req), 0);
        check_eq("reset_spawn", int'(spawn), 0);
        check_eq("reset_game_over", int'(game_over), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Keys in IDLE are ignored; then a new game.
        do_keys(1, 1, 1, 1, 1, 16'h0F00, 10);
        force_q = '{1'b1};
        do_start();
        // Rotate beats left.
        force_q = '{1'b1, 1'b1};
        do_keys(0, 0, 1, 1, 0, 16'h0F00, 10);
        // Tick and down merge into one op 0.
        force_q = '{1'b1};
        do_keys(1, 1, 0, 0, 0, 16'h0F00, 10);
        // Failing falls with row 1 at row 10: lock then clear then spawn.
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'h0F00, 10);
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'h0F00, 10);
        // Fail, committed left, fail, fail.
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'h0F00, 10);
        force_q = '{1'b1};
        do_keys(0, 0, 0, 1, 0, 16'h0F00, 10);
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'h0F00, 10);
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'h0F00, 10);
        // Row 0 at pos 23 overflows.
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'hF000, 23);
        force_q = '{1'b0, 1'b1};
        do_keys(1, 0, 0, 0, 0, 16'hF000, 23);
        check_eq("game_over_sticky", int'(game_over), int'(m_over));
        do_keys(1, 1, 1, 1, 1, 16'h0F00, 5);
        force_q = '{1'b1};
        do_start();
        check_eq("game_over_cleared", int'(game_over), 0);

        // Randomized rounds.
        for (int i = 0; i < 150; i++) begin
            if (m_over) begin
                if ($urandom_range(3) == 0) do_keys(1'($urandom_range(1)), 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F00, 5);
                else do_start();
            end else if ($urandom_range(9) == 0) begin
                // Start during play is ignored.
                pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                wait_drain();
            end else begin
                do_keys(1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0),
                        1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0),
                        shapes[$urandom_range(7)], ($urandom_range(4) == 0) ? $urandom_range(31) : $urandom_range(25, 17));
            end
        end

        // Asynchronous reset in the middle of a handshake.
        if (m_over) begin
            force_q = '{1'b1};
            do_start();
        end
        if (!m_over) begin
            hold_ack = 1'b1;
            push_ev(EV_CHK, 1, 3);
            pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            n = 0;
            while (!chk_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_eq("handshake_reached", int'(chk_req), 1);
            #2 rst_n = 1'b0;
            #1;
            check_eq("async_reset_chk_req", int'(chk_req), 0);
            check_eq("async_reset_state", int'(state), 0);
            exp_q.delete();
            resp_q.delete();
            m_over = 1'b1;
            m_grace = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            hold_ack = 1'b0;
            repeat (5) @(negedge clk);
            check_eq("after_reset_state", int'(state), 0);
            check_eq("after_reset_chk_req", int'(chk_req), 0);
            force_q = '{1'b1};
            do_start();
            force_q = '{1'b1, 1'b1};
            do_keys(0, 0, 0, 0, 1, 16'h0F00, 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
